color_manager_window_counter: RTL



---
 rtl/color_manager_pkg.sv | 16 +
 rtl/color_manager_axis_counter.sv | 51 +++++
 rtl/color_manager_window_counter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/color_manager_pkg.sv
// Shared definitions for the Color Manager window counter.
//   - Default porch/position widths for the horizontal and vertical axes.
//   - Frame FSM state encoding used by color_manager_window_counter.
package color_manager_pkg;

  localparam int unsigned H_WIDTH_DEFAULT = 11;
  localparam int unsigned V_WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    F_IDLE   = 2'd0,
    F_PORCH  = 2'd1,
    F_ACTIVE = 2'd2,
    F_DONE   = 2'd3
  } frame_state_e;

endpackage

// File: rtl/color_manager_axis_counter.sv
// One axis of the window counter: a saturating position counter with a strict
// window compare against the back/front porches.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   clear                 force position to 0 (takes priority over enable)
//   enable                advance position by one (saturates at all-ones)
//   sync                  axis sync level; window is closed while low
//   back_porch            last non-active position before the window
//   front_porch           first non-active position after the window
//   pos                   current position
//   in_window             sync & back_porch < pos < front_porch
module color_manager_axis_counter
  import color_manager_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             sync,
  input  logic [WIDTH-1:0] back_porch,
  input  logic [WIDTH-1:0] front_porch,
  output logic [WIDTH-1:0] pos,
  output logic             in_window
);

  localparam logic [WIDTH-1:0] PosMax = '1;

  logic [WIDTH-1:0] pos_d;

  always_comb begin
    pos_d = pos;
    if (clear) begin
      pos_d = '0;
    end else if (enable && (pos != PosMax)) begin
      pos_d = pos + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else begin
      pos <= pos_d;
    end
  end

  assign in_window = sync & (pos > back_porch) & (pos < front_porch);

endmodule

// File: rtl/color_manager_window_counter.sv
// Two-dimensional active-window counter sitting between the sync generator and
// the Color Manager pixel datapath. Counts cycles per line and lines per frame,
// gates both against programmable porches and emits per-pixel valid with
// active-area coordinates plus line-start and frame-done pulses.
// Ports:
//   Clk, rst                      clock, asynchronous active-high reset
//   HBackPorch, HFrontPorch       horizontal window bounds (exclusive)
//   VBackPorch, VFrontPorch       vertical window bounds (exclusive)
//   HSync, VSync                  high during a line / during a frame
//   Pixel_Valid, PixelX, PixelY   active pixel flag and 0-based coordinates
//   Line_Start                    pulse on first valid pixel of a line
//   Frame_Done                    pulse after a frame that had active pixels
//   Window_Error                  empty-window flag, sampled on VSync rise
// Optional build macro: COLOR_MANAGER_WINDOW_CHECK_EN enables the Window_Error
// check; when undefined Window_Error is tied low.
module color_manager_window_counter
  import color_manager_pkg::*;
#(
  parameter int unsigned H_WIDTH = H_WIDTH_DEFAULT,
  parameter int unsigned V_WIDTH = V_WIDTH_DEFAULT
) (
  input  logic               Clk,
  input  logic               rst,
  input  logic [H_WIDTH-1:0] HBackPorch,
  input  logic [H_WIDTH-1:0] HFrontPorch,
  input  logic [V_WIDTH-1:0] VBackPorch,
  input  logic [V_WIDTH-1:0] VFrontPorch,
  input  logic               HSync,
  input  logic               VSync,
  output logic               Pixel_Valid,
  output logic [H_WIDTH-1:0] PixelX,
  output logic [V_WIDTH-1:0] PixelY,
  output logic               Line_Start,
  output logic               Frame_Done,
  output logic               Window_Error
);

  localparam logic [V_WIDTH-1:0] PixelYMax = '1;

  logic               hsync_d;
  logic               armed;
  logic               line_active;
  logic               line_tick;
  logic               h_in;
  logic               v_in;
  logic               win;
  logic [H_WIDTH-1:0] h_pos;
  logic [V_WIDTH-1:0] v_pos;

  logic               pixel_valid_d;
  logic [H_WIDTH-1:0] pixel_x_d;
  logic [V_WIDTH-1:0] pixel_y_d;
  logic               line_start_d;
  logic               line_active_d;
  frame_state_e       state, state_d;

  assign line_tick = HSync & ~hsync_d;

  // Counters are held at 0 until a VSync low has been seen, so a reset in
  // mid-frame stays silent until the next complete frame.
  color_manager_axis_counter #(
    .WIDTH (H_WIDTH)
  ) u_h_axis (
    .clk         (Clk),
    .rst         (rst),
    .clear       (~armed | ~HSync),
    .enable      (1'b1),
    .sync        (HSync),
    .back_porch  (HBackPorch),
    .front_porch (HFrontPorch),
    .pos         (h_pos),
    .in_window   (h_in)
  );

  color_manager_axis_counter #(
    .WIDTH (V_WIDTH)
  ) u_v_axis (
    .clk         (Clk),
    .rst         (rst),
    .clear       (~armed | ~VSync),
    .enable      (line_tick),
    .sync        (VSync),
    .back_porch  (VBackPorch),
    .front_porch (VFrontPorch),
    .pos         (v_pos),
    .in_window   (v_in)
  );

  assign win = armed & h_in & v_in;

  always_comb begin
    pixel_valid_d = win;
    line_start_d  = win & ~Pixel_Valid;
    pixel_x_d     = '0;
    if (win && Pixel_Valid) begin
      pixel_x_d = PixelX + H_WIDTH'(1);
    end

    // line_active records whether the line just finished produced a pixel;
    // it is consumed (and cleared) by the next line_tick. Pixel_Valid and
    // line_tick can never coincide, since one needs HSync high on the previous
    // cycle and the other needs it low.
    pixel_y_d     = PixelY;
    line_active_d = line_active;
    if (!armed || !VSync) begin
      pixel_y_d     = '0;
      line_active_d = 1'b0;
    end else if (line_tick) begin
      line_active_d = 1'b0;
      if (line_active && (PixelY != PixelYMax)) begin
        pixel_y_d = PixelY + V_WIDTH'(1);
      end
    end else if (Pixel_Valid) begin
      line_active_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      F_IDLE: begin
        if (armed && VSync) state_d = F_PORCH;
      end
      F_PORCH: begin
        // A pixel landing on the VSync-low cycle still counts as activity.
        if (!VSync)          state_d = Pixel_Valid ? F_DONE : F_IDLE;
        else if (Pixel_Valid) state_d = F_ACTIVE;
      end
      F_ACTIVE: begin
        if (!VSync) state_d = F_DONE;
      end
      F_DONE: begin
        state_d = VSync ? F_PORCH : F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  assign Frame_Done = (state == F_DONE);

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      hsync_d     <= 1'b0;
      armed       <= 1'b0;
      line_active <= 1'b0;
      Pixel_Valid <= 1'b0;
      PixelX      <= '0;
      PixelY      <= '0;
      Line_Start  <= 1'b0;
      state       <= F_IDLE;
    end else begin
      hsync_d     <= HSync;
      armed       <= armed | ~VSync;
      line_active <= line_active_d;
      Pixel_Valid <= pixel_valid_d;
      PixelX      <= pixel_x_d;
      PixelY      <= pixel_y_d;
      Line_Start  <= line_start_d;
      state       <= state_d;
    end
  end

`ifdef COLOR_MANAGER_WINDOW_CHECK_EN
  logic vsync_d;
  logic h_empty;
  logic v_empty;

  // Widen by one bit so BackPorch+1 cannot wrap at all-ones.
  assign h_empty = {1'b0, HFrontPorch} <= ({1'b0, HBackPorch} + (H_WIDTH + 1)'(1));
  assign v_empty = {1'b0, VFrontPorch} <= ({1'b0, VBackPorch} + (V_WIDTH + 1)'(1));

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      Window_Error <= 1'b0;
    end else begin
      vsync_d <= VSync;
      if (VSync && !vsync_d) begin
        Window_Error <= h_empty | v_empty;
      end
    end
  end
`else
  assign Window_Error = 1'b0;
`endif

endmodule
